// File: rtl/ps2_key_decoder_if.sv
// Signal bundle between ps2_kbd, the key decoder and the CPU event port.
// The master modport is the decoder side; slave is the keyboard/CPU environment.
interface ps2_key_decoder_if;
    logic       kbd_ready;
    logic       kbd_overflow;
    logic [7:0] kbd_data;
    logic       kbd_read_enable;
    logic       ev_read;
    logic       ev_valid;
    logic [15:0] ev_data;
    logic [7:0] ev_ascii;
    logic       ev_overflow;
    logic       kbd_err;

    modport master (
        input  kbd_ready, kbd_overflow, kbd_data, ev_read,
        output kbd_read_enable, ev_valid, ev_data, ev_ascii, ev_overflow, kbd_err
    );

    modport slave (
        output kbd_ready, kbd_overflow, kbd_data, ev_read,
        input  kbd_read_enable, ev_valid, ev_data, ev_ascii, ev_overflow, kbd_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// Folds the PS/2 set-2 byte stream into key events with modifier state and ASCII,
// queued in a show-ahead FIFO for the CPU.
module ps2_key_decoder #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    ps2_key_decoder_if.master bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, GAP} state_t;
    state_t state, state_n;

    logic       ext_pend, brk_pend, err_q, ovf_q;
    logic       shift_l, shift_r, ctrl_l, ctrl_r, caps_lock, caps_held;
    logic       shift_l_n, shift_r_n, ctrl_l_n, ctrl_r_n, caps_lock_n, caps_held_n;
    logic       consume, is_e0, is_f0, is_ignored, ev_push;
    logic [7:0] sc, letter, ascii;
    logic [15:0] ev_word;

    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop, push_ok;

    // ---------------- fetch FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.kbd_ready) state_n = FETCH;
            FETCH:   state_n = GAP;
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign consume             = (state == FETCH) && !rst;
    assign bus.kbd_read_enable = consume;

    // ---------------- byte classification ----------------
    assign sc         = bus.kbd_data;
    assign is_e0      = (sc == 8'hE0);
    assign is_f0      = (sc == 8'hF0);
    assign is_ignored = (sc == 8'h00) || (sc == 8'hAA) || (sc == 8'hEE) ||
                        (sc == 8'hFA) || (sc == 8'hFE) || (sc == 8'hFF);
    assign ev_push    = consume && !is_e0 && !is_f0 && !is_ignored;

    // Overflow from the receiver wins over a prefix consumed on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (consume) begin
                if (is_e0) begin
                    ext_pend <= 1'b1;
                end else if (is_f0) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
            if (bus.kbd_overflow) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
                err_q    <= 1'b1;
            end
        end
    end

    // ---------------- modifiers ----------------
    always_comb begin
        shift_l_n   = shift_l;
        shift_r_n   = shift_r;
        ctrl_l_n    = ctrl_l;
        ctrl_r_n    = ctrl_r;
        caps_lock_n = caps_lock;
        caps_held_n = caps_held;
        if (ev_push && !ext_pend) begin
            case (sc)
                8'h12: shift_l_n = !brk_pend;
                8'h59: shift_r_n = !brk_pend;
                8'h14: ctrl_l_n  = !brk_pend;
                8'h58: begin
                    if (brk_pend) begin
                        caps_held_n = 1'b0;
                    end else if (!caps_held) begin
                        caps_lock_n = !caps_lock;
                        caps_held_n = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (ev_push && ext_pend && sc == 8'h14) begin
            ctrl_r_n = !brk_pend;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            ctrl_l    <= 1'b0;
            ctrl_r    <= 1'b0;
            caps_lock <= 1'b0;
            caps_held <= 1'b0;
        end else begin
            shift_l   <= shift_l_n;
            shift_r   <= shift_r_n;
            ctrl_l    <= ctrl_l_n;
            ctrl_r    <= ctrl_r_n;
            caps_lock <= caps_lock_n;
            caps_held <= caps_held_n;
        end
    end

    // ---------------- ASCII translation ----------------
    always_comb begin
        letter = '0;
        case (sc)
            8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
            8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
            8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
            8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
            8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
            8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
            default: letter = '0;
        endcase
    end

    always_comb begin
        ascii = '0;
        if (letter != '0) begin
            ascii = ((shift_l_n | shift_r_n) ^ caps_lock_n) ? (letter - 8'h20) : letter;
        end else begin
            case (sc)
                8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
                8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
                8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
                8'h46: ascii = 8'h39;  8'h29: ascii = 8'h20;  8'h5A: ascii = 8'h0D;
                8'h66: ascii = 8'h08;
                default: ascii = '0;
            endcase
        end
        if (brk_pend || ext_pend) ascii = '0;
    end

    assign ev_word = {brk_pend, ext_pend, shift_l_n | shift_r_n, ctrl_l_n | ctrl_r_n,
                      caps_lock_n, 3'b000, sc};

    // ---------------- event FIFO ----------------
    assign pop     = bus.ev_read && (count != '0);
    assign push_ok = ev_push && ((count != DEPTH_C) || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {ev_word, ascii};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (ev_push && !push_ok) ovf_q <= 1'b1;
        end
    end

    // Head is masked while empty so every output reads 0 out of reset.
    assign bus.ev_valid    = (count != '0);
    assign bus.ev_data     = bus.ev_valid ? mem[rd_ptr][23:8] : '0;
    assign bus.ev_ascii    = bus.ev_valid ? mem[rd_ptr][7:0]  : '0;
    assign bus.ev_overflow = ovf_q;
    assign bus.kbd_err     = err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: stimulus pushes expected events into a
// scoreboard queue, a monitor pops and compares as the DUT presents them.
module tb_ps2_key_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_key_decoder_if bus();
    ps2_key_decoder #(.FIFO_DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [15:0] d;
        logic [7:0]  a;
    } exp_t;
    exp_t exp_q[$];

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic drain_en = 1'b0;
    logic pop_req  = 1'b0;
    int unsigned pulse_cnt = 0;
    int unsigned wide_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [15:0] d, input logic [7:0] a);
        exp_t e;
        e.d = d;
        e.a = a;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: also owns ev_read.
    initial begin
        exp_t e;
        bus.ev_read = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ev_valid && (drain_en || pop_req)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {16'h0, bus.ev_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_data", {16'h0, bus.ev_data}, {16'h0, e.d});
                    chk("ev_ascii", {24'h0, bus.ev_ascii}, {24'h0, e.a});
                end
                bus.ev_read = 1'b1;
            end else begin
                bus.ev_read = 1'b0;
            end
        end
    end

    // Read-strobe pulse counter and width monitor.
    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.kbd_read_enable && !prev) pulse_cnt++;
            if (bus.kbd_read_enable && prev)  wide_cnt++;
            prev = bus.kbd_read_enable;
        end
    end

    task automatic wait_enable(input string name);
        int unsigned t = 0;
        while (!bus.kbd_read_enable && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.kbd_read_enable) chk(name, 32'h0, 32'h1);
    endtask

    // Emulates ps2_kbd: hold the byte until the decoder's pop edge.
    task automatic send_byte(input logic [7:0] b);
        bus.kbd_data  = b;
        bus.kbd_ready = 1'b1;
        wait_enable("fetch_timeout");
        @(posedge clk); #1;
        bus.kbd_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int unsigned t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
        @(posedge clk); #1;
        chk("empty_after_drain", {31'h0, bus.ev_valid}, 32'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ev_valid"},    {31'h0, bus.ev_valid},        32'h0);
        chk({tag, "_ev_data"},     {16'h0, bus.ev_data},         32'h0);
        chk({tag, "_ev_ascii"},    {24'h0, bus.ev_ascii},        32'h0);
        chk({tag, "_ev_overflow"}, {31'h0, bus.ev_overflow},     32'h0);
        chk({tag, "_kbd_err"},     {31'h0, bus.kbd_err},         32'h0);
        chk({tag, "_read_enable"}, {31'h0, bus.kbd_read_enable}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        bus.kbd_ready    = 1'b0;
        bus.kbd_overflow = 1'b0;
        bus.kbd_data     = 8'h00;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        drain_en = 1'b1;
        @(posedge clk); #1;

        // Make / break of 'a'
        base = pulse_cnt;
        expect_ev(16'h001C, 8'h61); send_byte(8'h1C);
        send_byte(8'hF0);
        expect_ev(16'h801C, 8'h00); send_byte(8'h1C);
        wait_drain();
        chk("read_pulses", pulse_cnt - base, 3);

        // Shift and Caps Lock
        expect_ev(16'h2012, 8'h00); send_byte(8'h12);
        expect_ev(16'h201C, 8'h41); send_byte(8'h1C);
        send_byte(8'hF0);
        expect_ev(16'h8012, 8'h00); send_byte(8'h12);
        expect_ev(16'h0858, 8'h00); send_byte(8'h58);
        send_byte(8'hF0);
        expect_ev(16'h8858, 8'h00); send_byte(8'h58);
        expect_ev(16'h081C, 8'h41); send_byte(8'h1C);
        wait_drain();

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Right Ctrl make and release
        send_byte(8'hE0);
        expect_ev(16'h5014, 8'h00); send_byte(8'h14);
        send_byte(8'hE0);
        send_byte(8'hF0);
        expect_ev(16'hC014, 8'h00); send_byte(8'h14);
        wait_drain();

        // Fill the FIFO with no reads: the 9th event is dropped
        drain_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_ev(16'h0016, 8'h31);
            send_byte(8'h16);
        end
        chk("ovf_before_full", {31'h0, bus.ev_overflow}, 32'h0);
        send_byte(8'h16);
        chk("ovf_after_drop", {31'h0, bus.ev_overflow}, 32'h1);
        chk("full_head", {16'h0, bus.ev_data}, 32'h0016);

        // Full FIFO: push and pop on the same edge
        expect_ev(16'h001E, 8'h32);
        bus.kbd_data  = 8'h1E;
        bus.kbd_ready = 1'b1;
        wait_enable("fetch_timeout");
        pop_req = 1'b1;
        @(posedge clk); #1;
        pop_req = 1'b0;
        bus.kbd_ready = 1'b0;
        chk("ovf_unchanged", {31'h0, bus.ev_overflow}, 32'h1);
        @(posedge clk); #1;
        drain_en = 1'b1;
        wait_drain();

        // Receiver overflow between F0 and the scancode
        send_byte(8'hF0);
        bus.kbd_overflow = 1'b1;
        @(posedge clk); #1;
        bus.kbd_overflow = 1'b0;
        chk("kbd_err", {31'h0, bus.kbd_err}, 32'h1);
        expect_ev(16'h001C, 8'h61); send_byte(8'h1C);
        wait_drain();

        // Reset while in FETCH: strobe drops at once, byte stays unread
        bus.kbd_data  = 8'h1C;
        bus.kbd_ready = 1'b1;
        wait_enable("fetch_timeout");
        rst = 1'b1;
        #1;
        chk("rst_drops_enable", {31'h0, bus.kbd_read_enable}, 32'h0);
        @(posedge clk); #1;
        chk_all_zero("rst_fetch");
        expect_ev(16'h001C, 8'h61);
        rst = 1'b0;
        wait_enable("refetch_timeout");
        @(posedge clk); #1;
        bus.kbd_ready = 1'b0;
        @(posedge clk); #1;
        wait_drain();

        chk("strobe_width", wide_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
